uart_sel_cmd_rx: RTL and testbench

- 8N1 UART receiver for the host-side rx line, paired with the tx2→tx3..tx6 / rx3..rx6→rx2 channel router.
- Deserialises frames into bytes and decodes ASCII command bytes '0'..'3' into a 2-bit channel select.
- The select replaces the s1/s0 switches as the router's selection source.
- Sits between the host UART pin and the router's select decoder.

---
 rtl/uart_pkg.sv | 6 +
 rtl/sync_2ff.sv | 18 +
 rtl/uart_sel_cmd_rx.sv | 85 ++++++++
 tb/tb_uart_sel_cmd_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default timing/command constants.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  localparam logic [7:0] CMD_BASE_DEFAULT = 8'h30;
  localparam int CLKS_PER_BIT_DEFAULT = 104;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous level, resetting to the idle-high value.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= 1'b1;
      o_q <= 1'b1;
    end else begin
      r_meta <= i_d;
      o_q <= r_meta;
    end
  end
endmodule

// File: rtl/uart_sel_cmd_rx.sv
// uart_sel_cmd_rx: 8N1 UART receiver that turns ASCII command bytes into a 2-bit router channel select.
module uart_sel_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] CMD_BASE = CMD_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic [1:0] sel,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic w_rx_s;
  logic [7:0] w_off;
  rx_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bidx;
  logic [7:0] r_shift;
  sync_2ff u_sync (.clk(clk), .reset(reset), .i_d(rx), .o_q(w_rx_s));
  // Offset from the first command byte; wraps so out-of-range bytes land at >= 4.
  assign w_off = r_shift - CMD_BASE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_bidx <= '0;
      r_shift <= '0;
      data <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      sel <= '0;
      busy <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        IDLE: if (!w_rx_s) begin
          r_state <= START;
          r_cnt <= '0;
          busy <= 1'b1;
        end
        START: if (r_cnt == HALF) begin
          r_cnt <= '0;
          r_bidx <= '0;
          r_state <= w_rx_s ? IDLE : DATA;
          busy <= !w_rx_s;
        end else r_cnt <= r_cnt + 1'b1;
        DATA: if (r_cnt == LAST) begin
          r_shift[r_bidx] <= w_rx_s;
          r_cnt <= '0;
          r_bidx <= r_bidx + 1'b1;
          if (r_bidx == 3'd7) r_state <= STOP;
        end else r_cnt <= r_cnt + 1'b1;
        STOP: if (r_cnt == LAST) begin
          r_cnt <= '0;
          if (w_rx_s) begin
            data <= r_shift;
            data_valid <= 1'b1;
            if (w_off < 8'd4) sel <= w_off[1:0];
            r_state <= IDLE;
            busy <= 1'b0;
          end else begin
            frame_err <= 1'b1;
            r_state <= WAIT_HIGH;
          end
        end else r_cnt <= r_cnt + 1'b1;
        WAIT_HIGH: if (w_rx_s) begin
          r_state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_sel_cmd_rx.sv
// tb_uart_sel_cmd_rx: directed and randomized frames checked against a byte-level receiver model.
module tb_uart_sel_cmd_rx;
  localparam int CPB = 16;
  logic clk = 1'b0, reset = 1'b0, rx = 1'b1;
  logic [7:0] data;
  logic data_valid, frame_err, busy;
  logic [1:0] sel;
  int n_tests = 0, n_fail = 0, fe_cnt = 0, both_cnt = 0, exp_fe = 0;
  logic [9:0] vq[$];
  logic [9:0] eq[$];
  logic [7:0] exp_data = 8'h00;
  logic [1:0] exp_sel = 2'b00;
  int f0;
  always #5 clk = ~clk;
  uart_sel_cmd_rx #(.CLKS_PER_BIT(CPB), .CMD_BASE(8'h30)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data), .data_valid(data_valid),
    .frame_err(frame_err), .sel(sel), .busy(busy)
  );
  always @(negedge clk) begin
    if (data_valid) vq.push_back({sel, data});
    if (frame_err) fe_cnt++;
    if (data_valid && frame_err) both_cnt++;
  end
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_data = b;
      if (b >= 8'h30 && b <= 8'h33) exp_sel = 2'(b - 8'h30);
      eq.push_back({exp_sel, exp_data});
    end else exp_fe++;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({data, data_valid, frame_err, sel, busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_vals: got data=%h dv=%b fe=%b sel=%b busy=%b, want all zero", data, data_valid, frame_err, sel, busy);
    end
    reset = 1'b1;
    idle(4);
  endtask
  task automatic test_single;
    vq.delete();
    f0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    idle(4);
    n_tests++;
    if (vq.size() != 1 || vq[0] !== {2'b00, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_frame: got %0d pulses first=%h, want 1 pulse %h", vq.size(), vq.size() > 0 ? vq[0] : 10'h0, {2'b00, 8'hA5});
    end
    n_tests++;
    if (fe_cnt - f0 != 0 || busy !== 1'b0 || data !== 8'hA5 || sel !== 2'b00) begin
      n_fail++;
      $display("FAIL single_state: got fe=%0d busy=%b data=%h sel=%b, want 0 0 a5 00", fe_cnt - f0, busy, data, sel);
    end
  endtask
  task automatic test_cmd;
    send_frame(8'h32, 1'b1);
    model_frame(8'h32, 1'b1);
    idle(4);
    n_tests++;
    if (sel !== 2'b10 || data !== 8'h32) begin
      n_fail++;
      $display("FAIL cmd_sel: got sel=%b data=%h, want 10 32", sel, data);
    end
    send_frame(8'h7A, 1'b1);
    model_frame(8'h7A, 1'b1);
    idle(4);
    n_tests++;
    if (sel !== 2'b10 || data !== 8'h7A) begin
      n_fail++;
      $display("FAIL noncmd_hold: got sel=%b data=%h, want 10 7a", sel, data);
    end
  endtask
  task automatic test_back_to_back;
    vq.delete();
    send_frame(8'h31, 1'b1);
    send_frame(8'h33, 1'b1);
    model_frame(8'h31, 1'b1);
    model_frame(8'h33, 1'b1);
    idle(4);
    n_tests++;
    if (vq.size() != 2 || vq[0] !== {2'b01, 8'h31} || vq[1] !== {2'b11, 8'h33}) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d pulses first=%h, want 2 pulses 131 then 333", vq.size(), vq.size() > 0 ? vq[0] : 10'h0);
    end
  endtask
  task automatic test_false_start;
    int k;
    vq.delete();
    f0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL false_start_busy: got busy=%b, want 1", busy);
    end
    k = 0;
    while (busy && k < 12) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL false_start_idle: busy=%b after %0d cycles, want 0 within 12", busy, k);
    end
    idle(2 * CPB);
    n_tests++;
    if (vq.size() != 0 || fe_cnt != f0 || data !== exp_data) begin
      n_fail++;
      $display("FAIL false_start_quiet: got %0d pulses fe=%0d data=%h, want 0 0 %h", vq.size(), fe_cnt - f0, data, exp_data);
    end
  endtask
  task automatic test_frame_err;
    vq.delete();
    f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (100 * CPB) @(negedge clk);
    idle(20);
    n_tests++;
    if (fe_cnt - f0 != 1 || vq.size() != 0 || data !== exp_data || sel !== exp_sel) begin
      n_fail++;
      $display("FAIL frame_err: got fe=%0d pulses=%0d data=%h sel=%b, want 1 0 %h %b", fe_cnt - f0, vq.size(), data, sel, exp_data, exp_sel);
    end
    send_frame(8'h30, 1'b1);
    model_frame(8'h30, 1'b1);
    idle(4);
    n_tests++;
    if (data !== 8'h30 || sel !== 2'b00 || vq.size() != 1) begin
      n_fail++;
      $display("FAIL after_err: got data=%h sel=%b pulses=%0d, want 30 00 1", data, sel, vq.size());
    end
  endtask
  task automatic test_reset_mid;
    logic [7:0] b;
    send_frame(8'h31, 1'b1);
    model_frame(8'h31, 1'b1);
    idle(4);
    vq.delete();
    f0 = fe_cnt;
    b = 8'h96;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    exp_data = 8'h00;
    exp_sel = 2'b00;
    n_tests++;
    if ({data, data_valid, frame_err, sel, busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL mid_reset_vals: got data=%h dv=%b fe=%b sel=%b busy=%b, want all zero", data, data_valid, frame_err, sel, busy);
    end
    idle(12 * CPB);
    n_tests++;
    if (vq.size() != 0 || fe_cnt != f0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: got pulses=%0d fe=%0d, want 0 0", vq.size(), fe_cnt - f0);
    end
    send_frame(8'h33, 1'b1);
    model_frame(8'h33, 1'b1);
    idle(4);
    n_tests++;
    if (data !== 8'h33 || sel !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_reset_next: got data=%h sel=%b, want 33 11", data, sel);
    end
  endtask
  task automatic test_random;
    logic [7:0] b;
    logic stop;
    vq.delete();
    eq.delete();
    f0 = fe_cnt;
    exp_fe = 0;
    repeat (20) begin
      b = $urandom_range(0, 1) ? 8'(8'h30 + $urandom_range(0, 3)) : 8'($urandom);
      stop = $urandom_range(0, 4) != 0;
      send_frame(b, stop);
      model_frame(b, stop);
      if (stop) idle($urandom_range(0, 12));
      else idle($urandom_range(4, 20));
    end
    idle(4);
    n_tests++;
    if (vq.size() != eq.size() || fe_cnt - f0 != exp_fe) begin
      n_fail++;
      $display("FAIL rand_counts: got pulses=%0d fe=%0d, want %0d %0d", vq.size(), fe_cnt - f0, eq.size(), exp_fe);
    end
    for (int i = 0; i < eq.size() && i < vq.size(); i++) begin
      n_tests++;
      if (vq[i] !== eq[i]) begin
        n_fail++;
        $display("FAIL rand_frame[%0d]: got sel/data=%h, want %h", i, vq[i], eq[i]);
      end
    end
    n_tests++;
    if (data !== exp_data || sel !== exp_sel || both_cnt != 0) begin
      n_fail++;
      $display("FAIL rand_final: got data=%h sel=%b overlap=%0d, want %h %b 0", data, sel, both_cnt, exp_data, exp_sel);
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_cmd();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
